// File: rtl/cv32e40x_rf_wport_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cv32e40x_rf_wport_arbiter: shares the RF write port between WB and XIF.  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module cv32e40x_rf_wport_arbiter #(
  parameter int unsigned XIF_FIFO_DEPTH = 2,
  parameter int unsigned STARVE_LIMIT   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_we_i,
  input  logic [4:0]  wb_waddr_i,
  input  logic [31:0] wb_wdata_i,
  output logic        wb_gnt_o,
  input  logic        xif_result_valid_i,
  output logic        xif_result_ready_o,
  input  logic [4:0]  xif_result_rd_i,
  input  logic        xif_result_we_i,
  input  logic        xif_result_exc_i,
  input  logic [31:0] xif_result_data_i,
  output logic        rf_we_o,
  output logic [4:0]  rf_waddr_o,
  output logic [31:0] rf_wdata_o,
  output logic [31:0] pend_rd_o,
  output logic        fifo_empty_o
);

  localparam int unsigned PTR_W = (XIF_FIFO_DEPTH > 1) ? $clog2(XIF_FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(XIF_FIFO_DEPTH + 1);
  localparam int unsigned SC_W  = $clog2(STARVE_LIMIT + 1);

  localparam logic [PTR_W-1:0] LAST_PTR   = PTR_W'(XIF_FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(XIF_FIFO_DEPTH);
  localparam logic [SC_W-1:0]  STARVE_MAX = SC_W'(STARVE_LIMIT);

  logic [4:0]                rd_q   [XIF_FIFO_DEPTH];
  logic [4:0]                rd_d   [XIF_FIFO_DEPTH];
  logic [31:0]               data_q [XIF_FIFO_DEPTH];
  logic [31:0]               data_d [XIF_FIFO_DEPTH];
  logic [XIF_FIFO_DEPTH-1:0] vld_q, vld_d;
  logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]          count_q, count_d;
  logic [SC_W-1:0]           starve_q, starve_d;

  logic        empty, full, wb_req, waw_hit, xif_wins, push, pop;
  logic [31:0] pend;

  always_comb begin
    empty  = (count_q == '0);
    full   = (count_q == FULL_CNT);
    wb_req = wb_we_i && (wb_waddr_i != 5'd0);

    pend = '0;
    for (int i = 0; i < int'(XIF_FIFO_DEPTH); i++) begin
      if (vld_q[i]) pend[rd_q[i]] = 1'b1;
    end

    waw_hit  = wb_req && pend[wb_waddr_i];
    // Reset suppresses any pop so discarded entries never reach the RF.
    xif_wins = !rst && !empty && (!wb_req || waw_hit || (starve_q == STARVE_MAX));
    pop      = xif_wins;
    // Results that cannot write (exception, no we, x0) are accepted and dropped.
    push     = !rst && xif_result_valid_i && !full && xif_result_we_i &&
               !xif_result_exc_i && (xif_result_rd_i != 5'd0);

    rd_d     = rd_q;
    data_d   = data_q;
    vld_d    = vld_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (push) begin
      rd_d[wr_ptr_q]   = xif_result_rd_i;
      data_d[wr_ptr_q] = xif_result_data_i;
      vld_d[wr_ptr_q]  = 1'b1;
      wr_ptr_d         = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      vld_d[rd_ptr_q] = 1'b0;
      rd_ptr_d        = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    starve_d = starve_q;
    if (empty || xif_wins) begin
      starve_d = '0;
    end else if (starve_q != STARVE_MAX) begin
      starve_d = starve_q + SC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      starve_q <= '0;
    end else begin
      vld_q    <= vld_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      starve_q <= starve_d;
    end
  end

  // Payload storage needs no reset; validity is tracked by vld_q.
  always_ff @(posedge clk) begin
    rd_q   <= rd_d;
    data_q <= data_d;
  end

  always_comb begin
    rf_we_o            = xif_wins || (wb_req && !rst);
    rf_waddr_o         = xif_wins ? rd_q[rd_ptr_q]   : wb_waddr_i;
    rf_wdata_o         = xif_wins ? data_q[rd_ptr_q] : wb_wdata_i;
    wb_gnt_o           = xif_wins ? !wb_req : 1'b1;
    xif_result_ready_o = rst || !full;
    fifo_empty_o       = rst || empty;
    pend_rd_o          = rst ? 32'd0 : pend;
  end

endmodule
`default_nettype wire
